// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : divider_pkg
// Brief    : Shared types and constants for the divider scratch-memory path.
// Revision : 1.0 - initial release
// ============================================================================
package divider_pkg;

   localparam int c_cdf_w          = 32;
   localparam int c_vals_per_word  = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_PRESENT = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Even-word address of pair k; callers truncate to their address width.
   function automatic int pair_addr(input int base, input int k);
      return base + 2 * k;
   endfunction

endpackage
`default_nettype wire

// File: rtl/divider_mem_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : divider_mem_rd_ctrl_if
// Brief    : Control, scratch-memory and divider-side bundle of the reader.
// Revision : 1.0 - initial release
// ============================================================================
interface divider_mem_rd_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 128
);
   logic              start;
   logic              div_ready;
   logic              sc_mem_rd_en;
   logic [ADDR_W-1:0] sc_mem_rd_addr1;
   logic [ADDR_W-1:0] sc_mem_rd_addr2;
   logic [DATA_W-1:0] sc_mem_rd_q1;
   logic [DATA_W-1:0] sc_mem_rd_q2;
   logic              sc_mem_rd_data_rdy;
   logic [DATA_W-1:0] sc_mem_rd_data1;
   logic [DATA_W-1:0] sc_mem_rd_data2;
   logic              busy;
   logic              done;

   modport master (
      input  start, div_ready, sc_mem_rd_q1, sc_mem_rd_q2,
      output sc_mem_rd_en, sc_mem_rd_addr1, sc_mem_rd_addr2,
             sc_mem_rd_data_rdy, sc_mem_rd_data1, sc_mem_rd_data2, busy, done
   );

   modport slave (
      output start, div_ready, sc_mem_rd_q1, sc_mem_rd_q2,
      input  sc_mem_rd_en, sc_mem_rd_addr1, sc_mem_rd_addr2,
             sc_mem_rd_data_rdy, sc_mem_rd_data1, sc_mem_rd_data2, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/divider_rd_lat_pipe.sv
`default_nettype none
// ============================================================================
// Module   : divider_rd_lat_pipe
// Brief    : RD_LAT-deep valid shift register marking the read-capture cycle.
// Revision : 1.0 - initial release
// ============================================================================
module divider_rd_lat_pipe #(
   parameter int RD_LAT = 1
) (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic i_issue,
   output logic      o_valid
);
   logic [RD_LAT:1] r_sr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sr <= '0;
      end else begin
         r_sr[1] <= i_issue;
         for (int i = 2; i <= RD_LAT; i++) begin
            r_sr[i] <= r_sr[i-1];
         end
      end
   end

   assign o_valid = r_sr[RD_LAT];
endmodule
`default_nettype wire

// File: rtl/divider_mem_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : divider_mem_rd_ctrl
// Brief    : Walks the CDF scratch memory in word pairs and hands each pair
//            to the divider. Option macro DIV_RD_PREFETCH_EN adds a one-pair
//            prefetch buffer.
// Revision : 1.0 - initial release
// ============================================================================
module divider_mem_rd_ctrl
   import divider_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 128,
   parameter int NUM_WORDS = 64,
   parameter int BASE_ADDR = 0,
   parameter int RD_LAT    = 1
) (
   input  wire logic               clk,
   input  wire logic               reset,
   divider_mem_rd_ctrl_if.master   rd_if
);
   localparam logic [ADDR_W-1:0] c_last   = ADDR_W'(NUM_WORDS / 2 - 1);
   localparam logic [ADDR_W-1:0] c_first1 = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] c_first2 = ADDR_W'(BASE_ADDR + 1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_k;
   logic [ADDR_W-1:0] r_addr1, r_addr2;
   logic              r_rd_en, r_done;
   logic [DATA_W-1:0] r_data1, r_data2;

   logic              w_cap, w_rd_en, w_rdy, w_last, w_load, w_pf_issue;
   logic [ADDR_W-1:0] w_nxt1, w_nxt2;
   logic [DATA_W-1:0] w_ld1, w_ld2;

   assign w_last = (r_k == c_last);
   assign w_rdy  = (r_state == ST_PRESENT) && rd_if.div_ready;
   assign w_nxt1 = ADDR_W'(pair_addr(BASE_ADDR, int'(r_k) + 1));
   assign w_nxt2 = ADDR_W'(pair_addr(BASE_ADDR, int'(r_k) + 1) + 1);
   assign w_rd_en = r_rd_en | w_pf_issue;

   divider_rd_lat_pipe #(.RD_LAT(RD_LAT)) u_lat_pipe (
      .clk     (clk),
      .reset   (reset),
      .i_issue (w_rd_en),
      .o_valid (w_cap)
   );

`ifdef DIV_RD_PREFETCH_EN
   logic              r_pf_out, r_pf_vld;
   logic [DATA_W-1:0] r_pf1, r_pf2;

   // A capture with no prefetch outstanding is the first pair of the pass.
   assign w_load     = (r_state == ST_WAIT) && ((w_cap && !r_pf_out) || r_pf_vld);
   assign w_pf_issue = w_load && !w_last;
   assign w_ld1      = r_pf_vld ? r_pf1 : rd_if.sc_mem_rd_q1;
   assign w_ld2      = r_pf_vld ? r_pf2 : rd_if.sc_mem_rd_q2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pf_out <= 1'b0;
         r_pf_vld <= 1'b0;
         r_pf1    <= '0;
         r_pf2    <= '0;
      end else if (r_state == ST_DONE) begin
         r_pf_out <= 1'b0;
         r_pf_vld <= 1'b0;
      end else begin
         if (w_pf_issue) begin
            r_pf_out <= 1'b1;
         end else if (w_cap && r_pf_out) begin
            r_pf_out <= 1'b0;
            r_pf_vld <= 1'b1;
            r_pf1    <= rd_if.sc_mem_rd_q1;
            r_pf2    <= rd_if.sc_mem_rd_q2;
         end
         if (w_load && r_pf_vld) begin
            r_pf_vld <= 1'b0;
         end
      end
   end
`else
   assign w_load     = (r_state == ST_WAIT) && w_cap;
   assign w_pf_issue = 1'b0;
   assign w_ld1      = rd_if.sc_mem_rd_q1;
   assign w_ld2      = rd_if.sc_mem_rd_q2;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_k     <= '0;
         r_rd_en <= 1'b0;
         r_done  <= 1'b0;
         r_addr1 <= '0;
         r_addr2 <= '0;
         r_data1 <= '0;
         r_data2 <= '0;
      end else begin
         r_rd_en <= 1'b0;
         r_done  <= 1'b0;
         if (w_pf_issue) begin
            r_addr1 <= w_nxt1;
            r_addr2 <= w_nxt2;
         end
         case (r_state)
            ST_IDLE: begin
               if (rd_if.start) begin
                  r_state <= ST_ISSUE;
                  r_k     <= '0;
                  r_rd_en <= 1'b1;
                  r_addr1 <= c_first1;
                  r_addr2 <= c_first2;
               end
            end
            ST_ISSUE: r_state <= ST_WAIT;
            ST_WAIT: begin
               if (w_load) begin
                  r_data1 <= w_ld1;
                  r_data2 <= w_ld2;
                  r_state <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (rd_if.div_ready) begin
                  if (w_last) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_k <= r_k + ADDR_W'(1);
`ifdef DIV_RD_PREFETCH_EN
                     r_state <= ST_WAIT;
`else
                     r_state <= ST_ISSUE;
                     r_rd_en <= 1'b1;
                     r_addr1 <= w_nxt1;
                     r_addr2 <= w_nxt2;
`endif
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // The prefetch read goes out in the cycle it is decided, so its address
   // bypasses the holding register for that one cycle.
   assign rd_if.sc_mem_rd_en       = w_rd_en;
   assign rd_if.sc_mem_rd_addr1    = w_pf_issue ? w_nxt1 : r_addr1;
   assign rd_if.sc_mem_rd_addr2    = w_pf_issue ? w_nxt2 : r_addr2;
   assign rd_if.sc_mem_rd_data_rdy = w_rdy;
   assign rd_if.sc_mem_rd_data1    = r_data1;
   assign rd_if.sc_mem_rd_data2    = r_data2;
   assign rd_if.busy               = (r_state != ST_IDLE);
   assign rd_if.done               = r_done;
endmodule
`default_nettype wire

// File: tb/tb_divider_mem_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_mem_rd_ctrl
// Brief    : Directed self-checking bench: three reader instances against
//            memory models that return the address replicated per word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_mem_rd_ctrl;
   import divider_pkg::*;

   localparam int AW = 8;
   localparam int DW = 128;
`ifdef DIV_RD_PREFETCH_EN
   localparam int PER_A = 2, PER_C = 3, STALL_RD = 2;
`else
   localparam int PER_A = 3, PER_C = 4, STALL_RD = 1;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   divider_mem_rd_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ia ();
   divider_mem_rd_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ib ();
   divider_mem_rd_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ic ();

   divider_mem_rd_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(4), .BASE_ADDR(0), .RD_LAT(1))
      dut_a (.clk(clk), .reset(reset), .rd_if(ia));
   divider_mem_rd_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(4), .BASE_ADDR(254), .RD_LAT(1))
      dut_b (.clk(clk), .reset(reset), .rd_if(ib));
   divider_mem_rd_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(8), .BASE_ADDR(0), .RD_LAT(2))
      dut_c (.clk(clk), .reset(reset), .rd_if(ic));

   function automatic logic [DW-1:0] wrd(input logic [AW-1:0] a);
      return {c_vals_per_word{{(c_cdf_w - AW){1'b0}}, a}};
   endfunction

   // Memory models: q = address replicated, RD_LAT cycles after rd_en
   logic [DW-1:0] qa1, qa2, qb1, qb2, qc1s, qc2s, qc1, qc2;
   always @(posedge clk) begin
      if (ia.sc_mem_rd_en) begin
         qa1 <= wrd(ia.sc_mem_rd_addr1);
         qa2 <= wrd(ia.sc_mem_rd_addr2);
      end
      if (ib.sc_mem_rd_en) begin
         qb1 <= wrd(ib.sc_mem_rd_addr1);
         qb2 <= wrd(ib.sc_mem_rd_addr2);
      end
      if (ic.sc_mem_rd_en) begin
         qc1s <= wrd(ic.sc_mem_rd_addr1);
         qc2s <= wrd(ic.sc_mem_rd_addr2);
      end
      qc1 <= qc1s;
      qc2 <= qc2s;
   end
   assign ia.sc_mem_rd_q1 = qa1;
   assign ia.sc_mem_rd_q2 = qa2;
   assign ib.sc_mem_rd_q1 = qb1;
   assign ib.sc_mem_rd_q2 = qb2;
   assign ic.sc_mem_rd_q1 = qc1;
   assign ic.sc_mem_rd_q2 = qc2;

   logic       ready = 1'b1;
   assign ia.div_ready = ready;
   assign ib.div_ready = ready;
   assign ic.div_ready = ready;

   // Event logs sampled on the falling edge
   logic [2*AW-1:0] rda[$], rdb[$], rdc[$];
   logic [2*DW-1:0] dta[$], dtb[$], dtc[$];
   int rca[$], rcc[$];
   int nda, ndb, ndc, dca, dcc;

   always @(negedge clk) begin
      if (ia.sc_mem_rd_en) rda.push_back({ia.sc_mem_rd_addr1, ia.sc_mem_rd_addr2});
      if (ib.sc_mem_rd_en) rdb.push_back({ib.sc_mem_rd_addr1, ib.sc_mem_rd_addr2});
      if (ic.sc_mem_rd_en) rdc.push_back({ic.sc_mem_rd_addr1, ic.sc_mem_rd_addr2});
      if (ia.sc_mem_rd_data_rdy) begin
         dta.push_back({ia.sc_mem_rd_data1, ia.sc_mem_rd_data2});
         rca.push_back(cyc);
      end
      if (ib.sc_mem_rd_data_rdy) dtb.push_back({ib.sc_mem_rd_data1, ib.sc_mem_rd_data2});
      if (ic.sc_mem_rd_data_rdy) begin
         dtc.push_back({ic.sc_mem_rd_data1, ic.sc_mem_rd_data2});
         rcc.push_back(cyc);
      end
      if (ia.done) begin nda++; dca = cyc; end
      if (ib.done) ndb++;
      if (ic.done) begin ndc++; dcc = cyc; end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_logs();
      rda.delete(); rdb.delete(); rdc.delete();
      dta.delete(); dtb.delete(); dtc.delete();
      rca.delete(); rcc.delete();
      nda = 0; ndb = 0; ndc = 0; dca = -1; dcc = -1;
   endtask

   task automatic pulse_start(input int which);
      case (which)
         0: ia.start = 1'b1;
         1: ib.start = 1'b1;
         default: ic.start = 1'b1;
      endcase
      tick();
      ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
   endtask

   task automatic wait_done(input int which, input int lim, output bit seen);
      seen = 1'b0;
      for (int n = 0; n < lim && !seen; n++) begin
         tick();
         case (which)
            0: seen = ia.done;
            1: seen = ib.done;
            default: seen = ic.done;
         endcase
      end
   endtask

   task automatic test_reset();
      repeat (2) tick();
      total++;
      if ({ia.sc_mem_rd_en, ia.sc_mem_rd_data_rdy, ia.busy, ia.done} !== 4'b0) begin
         bad++; $display("FAIL reset_ctl: got=%b exp=0000",
                         {ia.sc_mem_rd_en, ia.sc_mem_rd_data_rdy, ia.busy, ia.done});
      end
      total++;
      if ({ia.sc_mem_rd_addr1, ia.sc_mem_rd_addr2} !== 16'h0) begin
         bad++; $display("FAIL reset_addr: got=%h exp=0000", {ia.sc_mem_rd_addr1, ia.sc_mem_rd_addr2});
      end
      total++;
      if ({ia.sc_mem_rd_data1, ia.sc_mem_rd_data2} !== '0) begin
         bad++; $display("FAIL reset_data: got=%h exp=0", {ia.sc_mem_rd_data1, ia.sc_mem_rd_data2});
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      bit seen;
      ready = 1'b1;
      clr_logs();
      pulse_start(0);
      wait_done(0, 40, seen);
      tick();
      total++;
      if (seen !== 1'b1) begin bad++; $display("FAIL basic_done_seen: got=%b exp=1", seen); end
      total++;
      if (rda.size() !== 2) begin bad++; $display("FAIL basic_rd_count: got=%0d exp=2", rda.size()); end
      else begin
         total++;
         if (rda[0] !== 16'h0001 || rda[1] !== 16'h0203) begin
            bad++; $display("FAIL basic_rd_addr: got=%h,%h exp=0001,0203", rda[0], rda[1]);
         end
      end
      total++;
      if (dta.size() !== 2) begin bad++; $display("FAIL basic_rdy_count: got=%0d exp=2", dta.size()); end
      else begin
         total++;
         if (dta[0] !== {wrd(8'd0), wrd(8'd1)}) begin bad++; $display("FAIL basic_pair0: got=%h exp=%h", dta[0], {wrd(8'd0), wrd(8'd1)}); end
         total++;
         if (dta[1] !== {wrd(8'd2), wrd(8'd3)}) begin bad++; $display("FAIL basic_pair1: got=%h exp=%h", dta[1], {wrd(8'd2), wrd(8'd3)}); end
         total++;
         if (rca[1] - rca[0] !== PER_A) begin bad++; $display("FAIL basic_period: got=%0d exp=%0d", rca[1] - rca[0], PER_A); end
         total++;
         if (dca !== rca[1] + 1) begin bad++; $display("FAIL basic_done_cyc: got=%0d exp=%0d", dca, rca[1] + 1); end
      end
      total++;
      if ({ia.busy, ia.done, nda} !== {2'b00, 32'd1}) begin
         bad++; $display("FAIL basic_end: busy=%b done=%b ndone=%0d exp 0 0 1", ia.busy, ia.done, nda);
      end
   endtask

   task automatic test_stall();
      bit seen;
      ready = 1'b0;
      clr_logs();
      pulse_start(0);
      repeat (3) tick();
      total++;
      if ({ia.sc_mem_rd_data1, ia.sc_mem_rd_data2} !== {wrd(8'd0), wrd(8'd1)}) begin
         bad++; $display("FAIL stall_capture: got=%h exp=%h", {ia.sc_mem_rd_data1, ia.sc_mem_rd_data2}, {wrd(8'd0), wrd(8'd1)});
      end
      repeat (10) tick();
      total++;
      if (ia.sc_mem_rd_data_rdy !== 1'b0 || dta.size() !== 0) begin
         bad++; $display("FAIL stall_rdy: got rdy=%b pulses=%0d exp 0 0", ia.sc_mem_rd_data_rdy, dta.size());
      end
      total++;
      if (rda.size() !== STALL_RD) begin bad++; $display("FAIL stall_reads: got=%0d exp=%0d", rda.size(), STALL_RD); end
      total++;
      if ({ia.sc_mem_rd_data1, ia.sc_mem_rd_data2} !== {wrd(8'd0), wrd(8'd1)}) begin
         bad++; $display("FAIL stall_hold: got=%h exp=%h", {ia.sc_mem_rd_data1, ia.sc_mem_rd_data2}, {wrd(8'd0), wrd(8'd1)});
      end
      ready = 1'b1;
      #1;
      total++;
      if (ia.sc_mem_rd_data_rdy !== 1'b1) begin bad++; $display("FAIL stall_release: got=%b exp=1", ia.sc_mem_rd_data_rdy); end
      wait_done(0, 40, seen);
      tick();
      total++;
      if (dta.size() !== 2 || seen !== 1'b1) begin
         bad++; $display("FAIL stall_finish: got pulses=%0d done=%b exp 2 1", dta.size(), seen);
      end
      else begin
         total++;
         if (dta[1] !== {wrd(8'd2), wrd(8'd3)}) begin bad++; $display("FAIL stall_pair1: got=%h exp=%h", dta[1], {wrd(8'd2), wrd(8'd3)}); end
      end
   endtask

   task automatic test_ignore_start();
      bit seen;
      ready = 1'b1;
      clr_logs();
      pulse_start(0);
      repeat (2) tick();
      ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
      wait_done(0, 40, seen);
      ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
      repeat (8) tick();
      total++;
      if (seen !== 1'b1) begin bad++; $display("FAIL ign_done_seen: got=%b exp=1", seen); end
      total++;
      if (dta.size() !== 2 || rda.size() !== 2 || nda !== 1) begin
         bad++; $display("FAIL ign_counts: got rdy=%0d rd=%0d done=%0d exp 2 2 1", dta.size(), rda.size(), nda);
      end
      total++;
      if (ia.busy !== 1'b0) begin bad++; $display("FAIL ign_busy: got=%b exp=0", ia.busy); end
   endtask

   task automatic test_reset_mid();
      bit seen;
      bit found;
      ready = 1'b1;
      clr_logs();
      pulse_start(0);
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         if (ia.sc_mem_rd_en && ia.sc_mem_rd_addr1 == 8'd2) found = 1'b1;
         else tick();
      end
      total++;
      if (found !== 1'b1) begin bad++; $display("FAIL rmid_issue1: got=%b exp=1", found); end
      tick();
      reset = 1'b0;
      #2;
      total++;
      if ({ia.sc_mem_rd_en, ia.sc_mem_rd_data_rdy, ia.busy, ia.done} !== 4'b0) begin
         bad++; $display("FAIL rmid_ctl: got=%b exp=0000", {ia.sc_mem_rd_en, ia.sc_mem_rd_data_rdy, ia.busy, ia.done});
      end
      total++;
      if ({ia.sc_mem_rd_addr1, ia.sc_mem_rd_addr2, ia.sc_mem_rd_data1, ia.sc_mem_rd_data2} !== '0) begin
         bad++; $display("FAIL rmid_regs: got addr=%h data1=%h exp 0", {ia.sc_mem_rd_addr1, ia.sc_mem_rd_addr2}, ia.sc_mem_rd_data1);
      end
      tick();
      reset = 1'b1;
      tick();
      clr_logs();
      pulse_start(0);
      wait_done(0, 40, seen);
      tick();
      total++;
      if (rda.size() !== 2 || dta.size() !== 2) begin
         bad++; $display("FAIL rmid_restart_cnt: got rd=%0d rdy=%0d exp 2 2", rda.size(), dta.size());
      end
      else begin
         total++;
         if (rda[0] !== 16'h0001 || dta[0] !== {wrd(8'd0), wrd(8'd1)}) begin
            bad++; $display("FAIL rmid_restart_pair0: got addr=%h data=%h exp 0001 %h", rda[0], dta[0], {wrd(8'd0), wrd(8'd1)});
         end
      end
   endtask

   task automatic test_wrap();
      bit seen;
      ready = 1'b1;
      clr_logs();
      pulse_start(1);
      wait_done(1, 40, seen);
      tick();
      total++;
      if (rdb.size() !== 2 || dtb.size() !== 2 || ndb !== 1) begin
         bad++; $display("FAIL wrap_counts: got rd=%0d rdy=%0d done=%0d exp 2 2 1", rdb.size(), dtb.size(), ndb);
      end
      else begin
         total++;
         if (rdb[0] !== 16'hfeff || rdb[1] !== 16'h0001) begin
            bad++; $display("FAIL wrap_addr: got=%h,%h exp=feff,0001", rdb[0], rdb[1]);
         end
         total++;
         if (dtb[0] !== {wrd(8'd254), wrd(8'd255)} || dtb[1] !== {wrd(8'd0), wrd(8'd1)}) begin
            bad++; $display("FAIL wrap_data: got=%h exp=%h", dtb[0], {wrd(8'd254), wrd(8'd255)});
         end
      end
   endtask

   task automatic test_lat2_stream();
      bit seen;
      ready = 1'b1;
      clr_logs();
      pulse_start(2);
      wait_done(2, 100, seen);
      tick();
      total++;
      if (dtc.size() !== 4 || rdc.size() !== 4 || ndc !== 1) begin
         bad++; $display("FAIL lat2_counts: got rdy=%0d rd=%0d done=%0d exp 4 4 1", dtc.size(), rdc.size(), ndc);
      end
      else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (dtc[i] !== {wrd(AW'(2 * i)), wrd(AW'(2 * i + 1))}) begin
               bad++; $display("FAIL lat2_pair%0d: got=%h exp=%h", i, dtc[i], {wrd(AW'(2 * i)), wrd(AW'(2 * i + 1))});
            end
         end
         for (int i = 1; i < 4; i++) begin
            total++;
            if (rcc[i] - rcc[i-1] !== PER_C) begin
               bad++; $display("FAIL lat2_period%0d: got=%0d exp=%0d", i, rcc[i] - rcc[i-1], PER_C);
            end
         end
         total++;
         if (dcc !== rcc[3] + 1) begin bad++; $display("FAIL lat2_done_cyc: got=%0d exp=%0d", dcc, rcc[3] + 1); end
      end
   endtask

   initial begin
      ia.start = 1'b0;
      ib.start = 1'b0;
      ic.start = 1'b0;
      clr_logs();
      test_reset();
      test_basic();
      test_stall();
      test_ignore_start();
      test_reset_mid();
      test_wrap();
      test_lat2_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1);
   end
endmodule
`default_nettype wire
